// File: rtl/dac_spi_pkg.sv
// Frame layout and receiver state encoding for the DAC serial link.
// Shared by the transmitter and the receiver so both ends agree on bit positions.
package dac_spi_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 10;

  localparam int CFG_MSB  = 15;
  localparam int CFG_LSB  = 12;
  localparam int DATA_MSB = 11;
  localparam int DATA_LSB = 2;

  localparam logic [3:0] CFG_RESET = 4'b0011;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with an extra flop for edge detection.
// The rise/fall strobes are registered and are one cycle wide.
module sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic sysclk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic edge_r;
  logic rise_r;
  logic fall_r;

  // synchronizer chain, edge-detect flop and registered edge strobes
  always_ff @(posedge sysclk) begin
    if (reset) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      edge_r <= RST_VAL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      edge_r <= sync_r;
      rise_r <= sync_r & ~edge_r;
      fall_r <= ~sync_r & edge_r;
    end
  end

  assign level = sync_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/spi2dac_rx.sv
// Oversampled SPI responder that recovers the sample and config fields of a DAC frame.
// All serial inputs are sampled by sysclk; nothing is clocked by dac_sck.
module spi2dac_rx #(
  parameter int FRAME_BITS = dac_spi_pkg::FRAME_BITS,
  parameter int DATA_BITS  = dac_spi_pkg::DATA_BITS
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 dac_cs,
  input  logic                 dac_sck,
  input  logic                 dac_sdi,
  output logic [DATA_BITS-1:0] data_out,
  output logic [3:0]           config_out,
  output logic                 shdn,
  output logic                 data_valid,
  output logic                 frame_error
);

  import dac_spi_pkg::*;

  localparam int             CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic cs_level_s, cs_rise_s, cs_fall_s;
  logic sck_level_s, sck_rise_s, sck_fall_s;
  logic sck_unused_s;
  logic sdi_meta_r, sdi_sync_r;
  logic [1:0] flush_cnt_r;
  logic armed_r;

  rx_state_e             state_r, state_n;
  logic [FRAME_BITS-1:0] sr_r, sr_n;
  logic [CNT_W-1:0]      cnt_r, cnt_n;
  logic                  good_r, good_n;
  logic                  bad_r, bad_n;

  sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .sysclk (sysclk),
    .reset  (reset),
    .din    (dac_cs),
    .level  (cs_level_s),
    .rise   (cs_rise_s),
    .fall   (cs_fall_s)
  );

  sync_edge #(.RST_VAL(1'b1)) u_sck_sync (
    .sysclk (sysclk),
    .reset  (reset),
    .din    (dac_sck),
    .level  (sck_level_s),
    .rise   (sck_rise_s),
    .fall   (sck_fall_s)
  );

  // SCK level and falling edges play no part in framing
  assign sck_unused_s = sck_level_s ^ sck_fall_s;

  // data line needs no edge detection, only synchronization
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sdi_meta_r <= 1'b1;
      sdi_sync_r <= 1'b1;
    end else begin
      sdi_meta_r <= dac_sdi;
      sdi_sync_r <= sdi_meta_r;
    end
  end

  // arm frame entry only once the CS synchronizer holds post-reset samples showing CS high,
  // so a CS already low at reset release cannot fake a falling edge
  always_ff @(posedge sysclk) begin
    if (reset) begin
      flush_cnt_r <= 2'd0;
      armed_r     <= 1'b0;
    end else begin
      if (flush_cnt_r != 2'd3) begin
        flush_cnt_r <= flush_cnt_r + 2'd1;
      end
      if ((flush_cnt_r == 2'd3) && cs_level_s) begin
        armed_r <= 1'b1;
      end
    end
  end

  // frame FSM state, shift register, bit counter and end-of-frame verdict
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_r <= IDLE;
      sr_r    <= {FRAME_BITS{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      good_r  <= 1'b0;
      bad_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      sr_r    <= sr_n;
      cnt_r   <= cnt_n;
      good_r  <= good_n;
      bad_r   <= bad_n;
    end
  end

  // next-state logic; a CS rise takes priority over a coincident SCK rise
  always_comb begin
    state_n = state_r;
    sr_n    = sr_r;
    cnt_n   = cnt_r;
    good_n  = 1'b0;
    bad_n   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs_fall_s && armed_r) begin
          state_n = SHIFT;
          sr_n    = {FRAME_BITS{1'b0}};
          cnt_n   = {CNT_W{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (cs_rise_s) begin
          state_n = IDLE;
          if (cnt_r == CNT_GOOD) begin
            good_n = 1'b1;
          end else begin
            bad_n = 1'b1;
          end
        end else if (sck_rise_s) begin
          sr_n = {sr_r[FRAME_BITS-2:0], sdi_sync_r};
          if (cnt_r != CNT_MAX) begin
            cnt_n = cnt_r + CNT_ONE;
          end else begin
            cnt_n = cnt_r;
          end
        end else begin
          state_n = SHIFT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // held outputs and strobes; the shift register is stable here because
  // a new frame cannot start within three cycles of a CS rise
  always_ff @(posedge sysclk) begin
    if (reset) begin
      data_out    <= {DATA_BITS{1'b0}};
      config_out  <= CFG_RESET;
      shdn        <= 1'b0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      data_valid  <= good_r;
      frame_error <= bad_r;
      if (good_r) begin
        data_out   <= sr_r[DATA_LSB +: DATA_BITS];
        config_out <= sr_r[CFG_LSB +: 4];
        shdn       <= ~sr_r[CFG_LSB];
      end
    end
  end

endmodule
